// File: rtl/fdiv_arbiter_pkg.sv
// Shared FPU constants and types for the divider front-end arbiter.
// Holds state encoding, sequence lengths and field widths.
package fdiv_arbiter_pkg;

    localparam int MANT_W = 24;
    localparam int Q_W    = 32;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] ITER_LEN  = 5'd16;
    localparam logic [CNT_W-1:0] DRAIN_LEN = 5'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_DRAIN1,
        S_DRAIN2,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              id;
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } op_t;

endpackage

// File: rtl/fdiv_arbiter_rr_arb2.sv
// Two-way round-robin selector; prio=1 favours requester 1.
// Purely combinational, the pointer lives in the top.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = req0 & (~req1 | ~prio);
        gnt1 = req1 & (~req0 | prio);
    end

endmodule

// File: rtl/fdiv_arbiter.sv
// Two-requester front end for a fixed-latency mantissa divider.
// Grant -> 16 iteration cycles -> 2 drain cycles -> result strobe.
module fdiv_arbiter
    import fdiv_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [MANT_W-1:0] a0,
    input  logic [MANT_W-1:0] b0,
    input  logic [TAG_W-1:0]  tag0,
    input  logic              req1,
    input  logic [MANT_W-1:0] a1,
    input  logic [MANT_W-1:0] b1,
    input  logic [TAG_W-1:0]  tag1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic              stall1,
    output logic              div_fdiv,
    output logic [MANT_W-1:0] div_a,
    output logic [MANT_W-1:0] div_b,
    output logic              div_en,
    input  logic [Q_W-1:0]    div_q,
    input  logic              flush,
    output logic              res_valid,
    output logic              res_id,
    output logic [TAG_W-1:0]  res_tag,
    output logic [Q_W-1:0]    res_q,
    output logic              busy
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    op_t              op_q;
    logic             killed_q;
    logic             prio_q;
    logic             live_q;
    logic             open;
    logic             g0;
    logic             g1;
    logic             grant;
    logic             in_flight;

    // live_q keeps grants off until the first edge after reset release
    assign open = (state_q == S_IDLE || state_q == S_DONE)
                & live_q & ~flush;

    rr_arb2 u_rr (
        .req0 (req0 & open),
        .req1 (req1 & open),
        .prio (prio_q),
        .gnt0 (g0),
        .gnt1 (g1)
    );

    assign grant     = g0 | g1;
    assign in_flight = (state_q == S_ITER)
                     | (state_q == S_DRAIN1)
                     | (state_q == S_DRAIN2);

    always_comb begin
        gnt0      = g0;
        gnt1      = g1;
        stall0    = req0 & ~g0 & ~rst;
        stall1    = req1 & ~g1 & ~rst;
        div_fdiv  = grant;
        div_en    = (state_q == S_DRAIN1) | (state_q == S_DRAIN2);
        busy      = (state_q != S_IDLE);
        div_a     = (state_q == S_ITER) ? op_q.a : '0;
        div_b     = (state_q == S_ITER) ? op_q.b : '0;
        res_valid = (state_q == S_DONE) & ~killed_q & ~flush;
        res_q     = (state_q == S_DONE) ? div_q : '0;
        res_id    = op_q.id;
        res_tag   = op_q.tag;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (grant) state_d = S_ITER;
            S_ITER:   if (cnt_q == ITER_LEN) state_d = S_DRAIN1;
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: if (cnt_q == ITER_LEN + DRAIN_LEN) state_d = S_DONE;
            S_DONE:   state_d = grant ? S_ITER : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            killed_q <= 1'b0;
            prio_q   <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            if (grant) begin
                op_q.id  <= g1;
                op_q.a   <= g1 ? a1 : a0;
                op_q.b   <= g1 ? b1 : b0;
                op_q.tag <= g1 ? tag1 : tag0;
                cnt_q    <= 5'd1;
                killed_q <= 1'b0;
                prio_q   <= g0;
            end else begin
                // count runs 1..16 in ITER, then 17/18 through the drain
                if (state_q == S_ITER || state_q == S_DRAIN1)
                    cnt_q <= cnt_q + 5'd1;
                if (in_flight && flush)
                    killed_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter: vector table plus
// hand-written multi-cycle sequences (contention, flush, reset).
module tb_fdiv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [23:0] a0, b0, a1, b1;
    logic [4:0]  tag0, tag1;
    logic        gnt0, gnt1, stall0, stall1;
    logic        div_fdiv, div_en;
    logic [23:0] div_a, div_b;
    logic [31:0] div_q;
    logic        flush;
    logic        res_valid, res_id, busy;
    logic [4:0]  res_tag;
    logic [31:0] res_q;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fdiv_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .tag0(tag0),
        .req1(req1), .a1(a1), .b1(b1), .tag1(tag1),
        .gnt0(gnt0), .gnt1(gnt1),
        .stall0(stall0), .stall1(stall1),
        .div_fdiv(div_fdiv), .div_a(div_a), .div_b(div_b),
        .div_en(div_en), .div_q(div_q), .flush(flush),
        .res_valid(res_valid), .res_id(res_id),
        .res_tag(res_tag), .res_q(res_q), .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [23:0] a;
        logic [23:0] b;
        logic [4:0]  tag;
        logic [31:0] q;
        logic        fl10;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input int k,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @k=%0d: got %h expected %h",
                     nm, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [23:0] a,
                         input logic [23:0] b, input logic [4:0] t);
        if (id) begin
            req1 = 1'b1; a1 = a; b1 = b; tag1 = t;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; tag0 = t;
        end
    endtask

    task automatic run_vec(input vec_t v);
        tick();
        drive(v.id, v.a, v.b, v.tag);
        div_q = v.q;
        flush = 1'b0;
        #1;
        chk("gnt_self", 0, v.id ? gnt1 : gnt0, 1);
        chk("gnt_other", 0, v.id ? gnt0 : gnt1, 0);
        chk("stall_self", 0, v.id ? stall1 : stall0, 0);
        chk("div_fdiv_T", 0, div_fdiv, 1);
        chk("busy_T", 0, busy, 0);
        for (int k = 1; k <= 19; k++) begin
            tick();
            req0 = 1'b0;
            req1 = 1'b0;
            a0 = 24'h0; b0 = 24'h0;
            a1 = 24'h0; b1 = 24'h0;
            flush = v.fl10 && (k == 10);
            #1;
            chk("div_en", k, div_en, (k == 17 || k == 18));
            chk("busy", k, busy, 1);
            chk("div_fdiv", k, div_fdiv, 0);
            chk("res_valid", k, res_valid,
                (k == 19) && v.exp_valid);
            if (k == 1 || k == 16) begin
                chk("div_a", k, div_a, v.a);
                chk("div_b", k, div_b, v.b);
            end
            if (k == 19 && v.exp_valid) begin
                chk("res_id", k, res_id, v.id);
                chk("res_tag", k, res_tag, v.tag);
                chk("res_q", k, res_q, v.q);
            end
        end
        tick();
        flush = 1'b0;
        #1;
        chk("busy_after", 20, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 24'h800000, 24'hC00000, 5'd3,
                    32'h3F2AAAAB, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 24'hFFFFFF, 24'h800000, 5'd31,
                    32'h3FFFFFFF, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 24'h123456, 24'hABCDEF, 5'd0,
                    32'hDEADBEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 24'h800001, 24'hFFFFFE, 5'd17,
                    32'h00000001, 1'b0, 1'b1};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b1;
        a0 = '0; b0 = '0; tag0 = '0;
        a1 = '0; b1 = '0; tag1 = '0;
        div_q = 32'hCAFEF00D;
        flush = 1'b0;
        tick();
        tick();
        chk("rst_gnt1", 0, gnt1, 0);
        chk("rst_stall1", 0, stall1, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_res_valid", 0, res_valid, 0);
        chk("rst_res_q", 0, res_q, 0);
        chk("rst_div_en", 0, div_en, 0);
        req1 = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i]);

        // simultaneous requests: 0 wins, 1 waits for DONE
        for (int k = 0; k <= 38; k++) begin
            tick();
            if (k == 0) begin
                drive(1'b0, 24'h900000, 24'hA00000, 5'd1);
                drive(1'b1, 24'hB00000, 24'hC00000, 5'd2);
                div_q = 32'h11112222;
            end
            if (k == 1) req0 = 1'b0;
            if (k == 20) req1 = 1'b0;
            #1;
            chk("both_gnt0", k, gnt0, k == 0);
            chk("both_gnt1", k, gnt1, k == 19);
            chk("both_stall1", k, stall1, k <= 18);
            chk("both_valid", k, res_valid, (k == 19 || k == 38));
            if (k == 19) begin
                chk("both_id_a", k, res_id, 0);
                chk("both_tag_a", k, res_tag, 1);
            end
            if (k == 38) begin
                chk("both_id_b", k, res_id, 1);
                chk("both_tag_b", k, res_tag, 2);
                chk("both_q_b", k, res_q, 32'h11112222);
            end
        end

        // both held for four operations
        for (int k = 0; k <= 77; k++) begin
            tick();
            if (k == 0) begin
                drive(1'b0, 24'h800000, 24'h800000, 5'd4);
                drive(1'b1, 24'h800000, 24'h800000, 5'd5);
            end
            if (k == 58) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            #1;
            chk("rr_gnt0", k, gnt0, (k == 0 || k == 38));
            chk("rr_gnt1", k, gnt1, (k == 19 || k == 57));
            chk("rr_valid", k, res_valid,
                (k == 19 || k == 38 || k == 57 || k == 76));
            if (k == 76) chk("rr_last_id", k, res_id, 1);
        end

        // flush mid-ITER with a waiting requester
        for (int k = 0; k <= 39; k++) begin
            tick();
            if (k == 0) drive(1'b0, 24'hA5A5A5, 24'h5A5A5A, 5'd7);
            if (k == 1) begin
                req0 = 1'b0;
                drive(1'b1, 24'hC0FFEE, 24'hBEEF00, 5'd9);
            end
            if (k == 20) req1 = 1'b0;
            flush = (k == 10);
            #1;
            chk("fl_div_en", k, div_en,
                (k == 17 || k == 18 || k == 36 || k == 37));
            chk("fl_valid", k, res_valid, k == 38);
            chk("fl_gnt1", k, gnt1, k == 19);
            if (k == 21) chk("fl_div_a", k, div_a, 24'hC0FFEE);
            if (k == 38) chk("fl_tag", k, res_tag, 9);
        end

        // flush in IDLE blocks grant; flush at DONE kills the strobe
        tick();
        drive(1'b0, 24'h800000, 24'hF00000, 5'd11);
        flush = 1'b1;
        #1;
        chk("idle_fl_gnt0", 0, gnt0, 0);
        chk("idle_fl_stall0", 0, stall0, 1);
        chk("idle_fl_fdiv", 0, div_fdiv, 0);
        for (int k = 1; k <= 21; k++) begin
            tick();
            flush = (k == 20);
            if (k == 2) req0 = 1'b0;
            #1;
            chk("done_fl_gnt0", k, gnt0, k == 1);
            chk("done_fl_valid", k, res_valid, 0);
            if (k == 20) chk("done_fl_state", k, busy, 1);
        end
        flush = 1'b0;

        // reset mid-operation
        for (int k = 0; k <= 31; k++) begin
            tick();
            if (k == 0) drive(1'b1, 24'h900000, 24'h900000, 5'd13);
            if (k == 1) req1 = 1'b0;
            if (k == 8) begin
                rst = 1'b1;
                drive(1'b0, 24'h880000, 24'h990000, 5'd14);
                drive(1'b1, 24'h770000, 24'h660000, 5'd15);
            end
            if (k == 10) rst = 1'b0;
            if (k == 12) req0 = 1'b0;
            if (k == 31) req1 = 1'b0;
            #1;
            if (k == 0) chk("rs_gnt1_T", k, gnt1, 1);
            if (k == 8) begin
                chk("rs_busy", k, busy, 0);
                chk("rs_stall0", k, stall0, 0);
                chk("rs_stall1", k, stall1, 0);
                chk("rs_div_a", k, div_a, 0);
                chk("rs_div_b", k, div_b, 0);
                chk("rs_res_tag", k, res_tag, 0);
                chk("rs_res_id", k, res_id, 0);
                chk("rs_fdiv", k, div_fdiv, 0);
            end
            if (k >= 8) begin
                chk("rs_gnt0", k, gnt0, k == 11);
                chk("rs_gnt1", k, gnt1, k == 30);
                chk("rs_valid", k, res_valid, k == 30);
                chk("rs_div_en", k, div_en, (k == 28 || k == 29));
            end
            if (k == 11) chk("rs_stall1_w", k, stall1, 1);
            if (k == 30) chk("rs_res_tag2", k, res_tag, 14);
        end
        for (int k = 0; k < 22; k++) tick();
        chk("final_busy", 0, busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
